// File: rtl/dcim_pkg.sv
// Shared widths and scheduler state encoding for the DCIM MAC scheduler.
package dcim_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int ADDR_COUNT = 32;
    localparam int MULT_WIDTH = 32;
    localparam int ACC_WIDTH  = 37;
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/dcim_mac_accum.sv
// Job accumulator: clear on job accept, add product when enabled.
// DCIM_ACC_SAT_EN selects clamp-at-all-ones instead of modulo wrap.
module dcim_mac_accum
    import dcim_pkg::*;
#(
    parameter int ACC_W = ACC_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [MULT_WIDTH-1:0] i_prod,
    output logic [ACC_W-1:0]      o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_next_acc;

`ifdef DCIM_ACC_SAT_EN
    logic [ACC_W:0] w_sum;

    // One extra bit catches the carry out; once clamped, adds keep it clamped.
    assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(i_prod);
    assign w_next_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_next_acc = r_acc + ACC_W'(i_prod);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dcim_mac_scheduler.sv
// SRAM port arbiter and dot-product sequencer for the DCIM macro.
// Accumulator overflow mode is chosen by DCIM_ACC_SAT_EN (see dcim_mac_accum).
module dcim_mac_scheduler
    import dcim_pkg::*;
#(
    parameter int ACC_W = ACC_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hw_valid,
    output logic                  o_hw_ready,
    input  logic [ADDR_WIDTH-1:0] i_hw_addr,
    input  logic [DATA_WIDTH-1:0] i_hw_data,
    input  logic                  i_job_valid,
    output logic                  o_job_ready,
    input  logic [ADDR_WIDTH-1:0] i_job_addr,
    input  logic [LEN_WIDTH-1:0]  i_job_len,
    input  logic                  i_op_valid,
    output logic                  o_op_ready,
    input  logic [DATA_WIDTH-1:0] i_op_data,
    output logic                  o_sram_ce,
    output logic                  o_sram_we,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata,
    output logic [DATA_WIDTH-1:0] o_mult_a,
    output logic [DATA_WIDTH-1:0] o_mult_b,
    input  logic [MULT_WIDTH-1:0] i_mult_p,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [ACC_W-1:0]      o_res_data,
    output logic                  o_busy
);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic                  r_v1;
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic                  r_ce;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_idle;
    logic                  w_wr_acc;
    logic                  w_job_acc;
    logic                  w_op_ready;
    logic                  w_op_hs;
    logic                  w_last;
    logic [ACC_W-1:0]      w_acc;

    assign w_idle     = (r_state == IDLE);
    // Host write wins a tie with a job request.
    assign w_wr_acc   = w_idle && i_hw_valid;
    assign w_job_acc  = w_idle && i_job_valid && !i_hw_valid;
    assign w_op_ready = (r_state == RUN) && (r_issued < r_len);
    assign w_op_hs    = w_op_ready && i_op_valid;
    assign w_last     = w_op_hs && ((r_issued + LEN_WIDTH'(1)) == r_len);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_hw_valid) begin
                    w_next = WRITE;
                end else if (i_job_valid) begin
                    w_next = (i_job_len == '0) ? DONE : RUN;
                end
            end
            WRITE: w_next = IDLE;
            RUN: begin
                if (w_last) w_next = DRAIN;
            end
            DRAIN: begin
                if (!r_v1 && !r_v2) w_next = DONE;
            end
            DONE: begin
                if (i_res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr    <= '0;
            r_len    <= '0;
            r_issued <= '0;
        end else if (w_job_acc) begin
            r_ptr    <= i_job_addr;
            r_len    <= i_job_len;
            r_issued <= '0;
        end else if (w_op_hs) begin
            r_ptr    <= r_ptr + ADDR_WIDTH'(1);
            r_issued <= r_issued + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_ce <= w_wr_acc || w_op_hs;
            r_we <= w_wr_acc;
            if (w_wr_acc) begin
                r_addr  <= i_hw_addr;
                r_wdata <= i_hw_data;
            end else if (w_op_hs) begin
                r_addr <= r_ptr;
            end
        end
    end

    // v1: read in flight; v2: SRAM word and delayed operand at the multiplier.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_op1 <= '0;
            r_op2 <= '0;
        end else begin
            r_v1 <= w_op_hs;
            r_v2 <= r_v1;
            if (w_op_hs) r_op1 <= i_op_data;
            if (r_v1)    r_op2 <= r_op1;
        end
    end

    dcim_mac_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_job_acc),
        .i_en   (r_v2),
        .i_prod (i_mult_p),
        .o_acc  (w_acc)
    );

    assign o_hw_ready   = w_idle && !i_rst;
    assign o_job_ready  = w_idle && !i_rst && !i_hw_valid;
    assign o_op_ready   = w_op_ready;
    assign o_sram_ce    = r_ce;
    assign o_sram_we    = r_we;
    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_mult_a     = r_v2 ? r_op2 : '0;
    assign o_mult_b     = r_v2 ? i_sram_rdata : '0;
    assign o_res_valid  = (r_state == DONE);
    assign o_res_data   = w_acc;
    assign o_busy       = !w_idle;

endmodule
